muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide unit with its own HI/LO registers and sequencing controller. Sits beside the ALU in the Execute stage and accepts mult/multu/div/divu/mthi/mtlo from E. It models fixed MIPS latencies with a countdown and raises a stall request so that Decode holds any md-class instruction while the unit is busy. It also supplies HI/LO to the E-stage result mux for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu, counted after the start cycle; legal range 1..31.
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
E_start  input  1  E-stage instruction is a valid md op this cycle; single-cycle pulse.
E_md_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
E_a  input  32  rs operand, already forwarded.
E_b  input  32  rt operand, already forwarded.
D_md_use  input  1  D-stage instruction is any md-class op (mult..mtlo, mfhi, mflo).
busy  output  1  unit is occupied.
md_stall  output  1  stall request to the hazard unit.
hi  output  32  HI register.
lo  output  32  LO register.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; cnt=0; hi=0; lo=0; pending results=0. Reset in the middle of an operation aborts it with no commit.
- States:
  - IDLE -> BUSY on E_start with op 1..4. Same edge: latch computed result into pend_hi/pend_lo; cnt = MULT_CYCLES or DIV_CYCLES.
  - BUSY: cnt decrements on every edge. At the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state->IDLE.
- Visible latency: the new HI/LO value appears exactly N+1 edges after the start edge, where N is MULT_CYCLES or DIV_CYCLES.
- busy = E_start&(op in 1..4) | (state==BUSY). It is combinational on the start cycle, as MIPS P6 semantics require.
- busy stays high through the cycle in which cnt==1. It is low on the cycle after commit.
- md_stall = D_md_use & busy.
- mthi/mtlo: in IDLE, hi<=E_a or lo<=E_a at the next edge. busy is not asserted for these ops.
- E_start with any op while state==BUSY: ignored. The hazard unit guarantees this cannot occur; the verification bench flags it with an assertion.
- op 0 or 7 with E_start: no effect.
- mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. multu: same, unsigned.
- div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divisor == 0 (div or divu): full busy period is still taken, but HI/LO are left unchanged at commit.
- Operands are sampled only on the start edge. Later changes on E_a/E_b have no effect.
- Arithmetic may be written as behavioural * and / on the latched operands. No iterative datapath is required.

Decomposition:
- Shared package/header: MD_* op encodings (MD_NONE..MD_MTLO), state encodings (MDS_IDLE, MDS_BUSY), default cycle counts.
- One sub-module, md_arith: purely combinational. Takes op, a and b; produces res_hi, res_lo and div_zero. Keeps the signed/unsigned and div-by-zero rules separate from the sequencing FSM.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3, start at edge 0 -> busy high for cycles 0..5; at edge 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy low in cycle 6.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 6 edges hi=0xFFFFFFFE, lo=0x00000001.
- div, a=-7 (0xFFFFFFF9), b=2 -> after 11 edges lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 from hi=0x11, lo=0x22 -> busy for 11 cycles, HI/LO stay 0x11/0x22.
- Hazard: D_md_use=1 during a div -> md_stall high from the start cycle through the last busy cycle, low after commit; D_md_use=0 -> md_stall=0 throughout.
- mthi a=0xDEADBEEF, then mtlo a=0x12345678 on consecutive cycles -> hi/lo update on the next edges; busy never rises.
- reset driven low in busy cycle 3 of a mult -> hi=lo=0 immediately (asynchronous); busy=0; after release, no commit occurs.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, controller states
// and default latencies.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 5;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_arith.sv
// Combinational multiply/divide datapath: MIPS signed/unsigned product,
// quotient/remainder and divide-by-zero detection.
module md_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // Sign-extending to 64 bits lets one unsigned multiplier produce the
  // two's-complement signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'h0, i_a} * {32'h0, i_b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly
  // instead of overflowing a native signed divide.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_neg      = w_signed_div && i_a[31];
  assign w_b_neg      = w_signed_div && i_b[31];
  assign w_mag_a      = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_mag_b      = w_b_neg ? (~i_b + 32'd1) : i_b;
  assign o_div_zero   = md_is_div(i_op) && (i_b == 32'h0);
  assign w_div_b      = o_div_zero ? 32'd1 : w_mag_b;
  assign w_quot       = w_mag_a / w_div_b;
  assign w_rem        = w_mag_a % w_div_b;
  assign w_quot_fix   = (w_a_neg ^ w_b_neg) ? (~w_quot + 32'd1) : w_quot;
  assign w_rem_fix    = w_a_neg ? (~w_rem + 32'd1) : w_rem;

  always_comb begin
    o_res_hi = 32'h0;
    o_res_lo = 32'h0;
    case (md_op_e'(i_op))
      MD_MULT: begin
        o_res_hi = w_prod_s[63:32];
        o_res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        o_res_hi = w_prod_u[63:32];
        o_res_lo = w_prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        o_res_hi = w_rem_fix;
        o_res_lo = w_quot_fix;
      end
      default: begin
        o_res_hi = 32'h0;
        o_res_lo = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage multiply/divide unit: HI/LO registers, fixed-latency busy
// countdown and the Decode stall request for md-class instructions.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_a,
  input  logic [31:0] E_b,
  input  logic        D_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_CYCLES);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [31:0]         r_pend_hi;
  logic [31:0]         r_pend_lo;
  logic                r_pend_dz;

  logic [31:0]         w_res_hi;
  logic [31:0]         w_res_lo;
  logic                w_div_zero;
  logic                w_idle;
  logic                w_long_start;
  logic                w_load;
  logic                w_commit;
  logic                w_mthi;
  logic                w_mtlo;

  assign w_idle       = (r_state == MDS_IDLE);
  assign w_long_start = E_start && md_is_long(E_md_op);
  assign w_load       = w_idle && w_long_start;
  assign w_mthi       = w_idle && E_start && (E_md_op == MD_MTHI);
  assign w_mtlo       = w_idle && E_start && (E_md_op == MD_MTLO);

  md_arith u_md_arith (
    .i_op       (E_md_op),
    .i_a        (E_a),
    .i_b        (E_b),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      MDS_IDLE: begin
        if (w_long_start) begin
          w_state_nxt = MDS_BUSY;
          w_cnt_nxt   = md_is_div(E_md_op) ? DIV_CNT : MULT_CNT;
        end
      end
      MDS_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_commit    = 1'b1;
          w_state_nxt = MDS_IDLE;
        end
      end
      default: w_state_nxt = MDS_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MDS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Results are computed from the start-cycle operands and parked until the
  // countdown expires; a zero divisor keeps the old HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi      <= 32'h0;
      r_lo      <= 32'h0;
      r_pend_hi <= 32'h0;
      r_pend_lo <= 32'h0;
      r_pend_dz <= 1'b0;
    end else begin
      if (w_load) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_dz <= w_div_zero;
      end
      if (w_commit) begin
        if (!r_pend_dz) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else begin
        if (w_mthi) r_hi <= E_a;
        if (w_mtlo) r_lo <= E_a;
      end
    end
  end

  // busy covers the start cycle combinationally so Decode holds immediately.
  assign busy     = w_long_start || (r_state == MDS_BUSY);
  assign md_stall = D_md_use && busy;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboarded mult/div results, busy
// length, stall request, mthi/mtlo and asynchronous reset abort.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_a;
  logic [31:0] E_b;
  logic        D_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .E_start  (E_start),
    .E_md_op  (E_md_op),
    .E_a      (E_a),
    .E_b      (E_b),
    .D_md_use (D_md_use),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always @(posedge clk) begin
    if (reset === 1'b1 && E_start === 1'b1)
      assert (dut.r_state != MDS_BUSY) else $error("md start issued while unit busy");
  end

  // Reference model written with 64-bit native arithmetic.
  function automatic void md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi_in, input logic [31:0] lo_in,
                                   output logic [31:0] hi_o, output logic [31:0] lo_o);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    hi_o = hi_in;
    lo_o = lo_in;
    case (op)
      MD_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi_o = sp[63:32];
        lo_o = sp[31:0];
      end
      MD_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        hi_o = up[63:32];
        lo_o = up[31:0];
      end
      MD_DIV: if (b != 32'h0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        lo_o = q[31:0];
        hi_o = r[31:0];
      end
      MD_DIVU: if (b != 32'h0) begin
        lo_o = a / b;
        hi_o = a % b;
      end
      default: ;
    endcase
  endfunction

  task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d_use, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string name);
    exp_t e;
    int   cyc;
    e.hi     = exp_hi;
    e.lo     = exp_lo;
    e.cycles = md_is_div(op) ? DIV_N + 1 : MULT_N + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = op; E_a = a; E_b = b; D_md_use = d_use;
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      n_checks++;
      if (md_stall !== d_use) begin
        n_fail++;
        $display("FAIL %s stall cycle %0d: got %b want %b", name, cyc, md_stall, d_use);
      end
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL %s early_commit cycle %0d: got %h/%h want %h/%h", name, cyc, hi, lo, m_hi, m_lo);
      end
      @(posedge clk); #1;
      E_start = 1'b0; E_md_op = MD_NONE; E_a = $urandom; E_b = $urandom;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_checks++;
    if (cyc !== e.cycles) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d want %0d", name, cyc, e.cycles);
    end
    n_checks++;
    if (hi !== e.hi) begin
      n_fail++;
      $display("FAIL %s hi: got %h want %h", name, hi, e.hi);
    end
    n_checks++;
    if (lo !== e.lo) begin
      n_fail++;
      $display("FAIL %s lo: got %h want %h", name, lo, e.lo);
    end
    n_checks++;
    if (md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall_after: got %b want 0", name, md_stall);
    end
    m_hi = e.hi;
    m_lo = e.lo;
    D_md_use = 1'b0;
  endtask

  task automatic write_hilo(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = op; E_a = a;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_busy op %0d: got %b want 0", op, busy);
    end
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = MD_NONE; E_a = $urandom;
    if (op == MD_MTHI) m_hi = a;
    else m_lo = a;
  endtask

  task automatic test_reset();
    reset = 1'b0; E_start = 1'b0; E_md_op = MD_NONE; E_a = 32'h0; E_b = 32'h0; D_md_use = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
    end
    n_checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got busy %b stall %b want 0 0", busy, md_stall);
    end
    reset = 1'b1;
    D_md_use = 1'b0;
  endtask

  task automatic test_mult();
    run_long(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    run_long(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "multu");
  endtask

  task automatic test_div();
    run_long(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_long(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, "div_ovf");
  endtask

  task automatic test_mthi_mtlo();
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = MD_MTHI; E_a = 32'hDEADBEEF; D_md_use = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_busy: got busy %b stall %b want 0 0", busy, md_stall);
    end
    @(posedge clk); #1;
    E_md_op = MD_MTLO; E_a = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (hi !== 32'hDEADBEEF || lo !== m_lo) begin
      n_fail++;
      $display("FAIL mthi_value: got %h/%h want deadbeef/%h", hi, lo, m_lo);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo_busy: got %b want 0", busy);
    end
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = MD_NONE; E_a = 32'h0; D_md_use = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mtlo_value: got %h/%h want deadbeef/12345678", hi, lo);
    end
    m_hi = 32'hDEADBEEF;
    m_lo = 32'h12345678;
  endtask

  task automatic test_divu_zero();
    write_hilo(MD_MTHI, 32'h11);
    write_hilo(MD_MTLO, 32'h22);
    run_long(MD_DIVU, 32'd7, 32'd0, 1'b0, 32'h11, 32'h22, "divu_zero");
    run_long(MD_DIV, 32'hFFFFFFF0, 32'd0, 1'b1, 32'h11, 32'h22, "div_zero");
  endtask

  task automatic test_stall();
    run_long(MD_DIV, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, "stall_div");
    run_long(MD_MULT, 32'h00010000, 32'h00010000, 1'b0, 32'h1, 32'h0, "nostall_mult");
  endtask

  task automatic test_nop_ops();
    logic [2:0] ops[2];
    ops[0] = MD_NONE;
    ops[1] = MD_RSVD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      E_start = 1'b1; E_md_op = ops[i]; E_a = $urandom; E_b = $urandom; D_md_use = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || md_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL nop_busy op %0d: got busy %b stall %b want 0 0", ops[i], busy, md_stall);
      end
      @(posedge clk); #1;
      E_start = 1'b0; E_md_op = MD_NONE; D_md_use = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL nop_hilo op %0d: got %h/%h want %h/%h", ops[i], hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_long(MD_MULTU, 32'h12345678, 32'h10, 1'b0, 32'h1, 32'h23456780, "b2b_multu");
    run_long(MD_DIV, 32'd100, 32'hFFFFFFF9, 1'b1, 32'd2, 32'hFFFFFFF2, "b2b_div");
    run_long(MD_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0, 32'hF, 32'h0FFFFFFF, "b2b_divu");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (i[0]) b = b >> $urandom_range(0, 28);
      md_model(op, a, b, m_hi, m_lo, eh, el);
      run_long(op, a, b, 1'($urandom_range(0, 1)), eh, el, "random");
    end
  endtask

  task automatic test_reset_abort();
    write_hilo(MD_MTHI, 32'h11);
    write_hilo(MD_MTLO, 32'h22);
    @(posedge clk); #1;
    E_start = 1'b1; E_md_op = MD_MULT; E_a = 32'd3; E_b = 32'd5; D_md_use = 1'b1;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = MD_NONE;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || hi !== 32'h11) begin
      n_fail++;
      $display("FAIL abort_pre: got busy %b hi %h want 1 11", busy, hi);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo);
    end
    n_checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got busy %b stall %b want 0 0", busy, md_stall);
    end
    @(negedge clk);
    reset = 1'b1;
    D_md_use = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_commit: got %h/%h busy %b want 0/0 busy 0", hi, lo, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_divu_zero();
    test_stall();
    test_nop_ops();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
